keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad and delivers debounced key codes to the microcontroller's keypad lines. It drives one active-low column at a time and samples the four row inputs. After debouncing it presents a 4-bit key code on `Key`, which feeds the P1 upper nibble, and pulses the active-low `KeyIntr`, which feeds INT0 (P3.2). It sits directly upstream of the FPGA pin-mapping block.

---
 rtl/keypad_scanner_pkg.sv | 41 ++++
 rtl/keypad_tick_gen.sv | 35 +++
 rtl/keypad_scanner.sv | 212 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM state encoding,
// matrix geometry, idle row pattern and small decode helpers.
package keypad_scanner_pkg;

  localparam int KEY_W    = 4;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [NUM_ROWS-1:0] ROW_IDLE = 4'hF;

  typedef enum logic [2:0] {
    ST_SCAN      = 3'd0,
    ST_DEB_PRESS = 3'd1,
    ST_REPORT    = 3'd2,
    ST_HOLD      = 3'd3,
    ST_DEB_REL   = 3'd4
  } state_t;

  // Lowest-index low row wins when several keys share a column.
  function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] rows);
    logic [1:0] idx;
    if (!rows[0]) begin
      idx = 2'd0;
    end else if (!rows[1]) begin
      idx = 2'd1;
    end else if (!rows[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] col);
    logic [NUM_COLS-1:0] drv;
    drv      = 4'b1111;
    drv[col] = 1'b0;
    return drv;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan prescaler: counts 0..SCAN_DIV-1 and raises a registered one-cycle tick
// while the count sits at SCAN_DIV-1.
module keypad_tick_gen #(
  parameter int SCAN_DIV = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  output logic tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST     = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE_LAST = CW'(SCAN_DIV - 2);

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // Prescaler count; tick is pre-decoded one count early so it is a flop output.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
      tick_r <= (cnt_r == CNT_PRE_LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce, latched key code and active-low
// interrupt pulse. Optional auto-repeat is enabled by KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3,
  parameter int INTR_WIDTH   = 8,
  parameter int REPEAT_TICKS = 20
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [NUM_ROWS-1:0] KeyRow,
  output logic [NUM_COLS-1:0] KeyCol,
  output logic [KEY_W-1:0]    Key,
  output logic                KeyIntr
);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || INTR_WIDTH < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("keypad_scanner: illegal parameter value");
  end

  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  localparam int PW = $clog2(INTR_WIDTH + 1);
  localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE_CNT);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(INTR_WIDTH - 1);

  logic [NUM_ROWS-1:0] sync1_r;
  logic [NUM_ROWS-1:0] rs_r;
  state_t              state_r;
  state_t              state_nxt_s;
  logic [1:0]          col_r;
  logic [1:0]          col_nxt_s;
  logic [1:0]          row_r;
  logic [1:0]          row_nxt_s;
  logic [DW-1:0]       deb_r;
  logic [DW-1:0]       deb_nxt_s;
  logic [DW-1:0]       deb_inc_s;
  logic                report_s;
  logic [NUM_COLS-1:0] col_drv_r;
  logic [KEY_W-1:0]    key_r;
  logic [PW-1:0]       pulse_r;
  logic                intr_r;
  logic                tick_s;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_TICKS);
  logic [RW-1:0] rep_r;
  logic [RW-1:0] rep_nxt_s;
  logic [RW-1:0] rep_inc_s;
  assign rep_inc_s = rep_r + RW'(1);
`endif

  assign deb_inc_s = deb_r + DW'(1);

  keypad_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick_gen (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .tick  (tick_s)
  );

  // Two-flop row synchronizer; idle (all high) out of reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      sync1_r <= ROW_IDLE;
      rs_r    <= ROW_IDLE;
    end else begin
      sync1_r <= KeyRow;
      rs_r    <= sync1_r;
    end
  end

  // Scan / debounce / report next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    col_nxt_s   = col_r;
    row_nxt_s   = row_r;
    deb_nxt_s   = deb_r;
    report_s    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_nxt_s   = rep_r;
`endif
    case (state_r)
      ST_SCAN: begin
        if (tick_s) begin
          if (rs_r == ROW_IDLE) begin
            col_nxt_s = col_r + 2'd1;
          end else begin
            row_nxt_s   = lowest_low(rs_r);
            deb_nxt_s   = '0;
            state_nxt_s = ST_DEB_PRESS;
          end
        end else begin
          state_nxt_s = ST_SCAN;
        end
      end
      ST_DEB_PRESS: begin
        if (tick_s) begin
          if (!rs_r[row_r]) begin
            deb_nxt_s = deb_inc_s;
            if (deb_inc_s == DEB_MAX) begin
              state_nxt_s = ST_REPORT;
            end else begin
              state_nxt_s = ST_DEB_PRESS;
            end
          end else begin
            state_nxt_s = ST_SCAN;
          end
        end else begin
          state_nxt_s = ST_DEB_PRESS;
        end
      end
      ST_REPORT: begin
        report_s    = 1'b1;
        state_nxt_s = ST_HOLD;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_nxt_s   = '0;
`endif
      end
      ST_HOLD: begin
        if (tick_s) begin
          if (rs_r == ROW_IDLE) begin
            deb_nxt_s   = '0;
            state_nxt_s = ST_DEB_REL;
          end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rep_inc_s == REP_MAX) begin
              rep_nxt_s   = '0;
              state_nxt_s = ST_REPORT;
            end else begin
              rep_nxt_s   = rep_inc_s;
              state_nxt_s = ST_HOLD;
            end
`else
            state_nxt_s = ST_HOLD;
`endif
          end
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_DEB_REL: begin
        if (tick_s) begin
          if (rs_r == ROW_IDLE) begin
            deb_nxt_s = deb_inc_s;
            if (deb_inc_s == DEB_MAX) begin
              col_nxt_s   = col_r + 2'd1;
              state_nxt_s = ST_SCAN;
            end else begin
              state_nxt_s = ST_DEB_REL;
            end
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end else begin
          state_nxt_s = ST_DEB_REL;
        end
      end
      default: begin
        state_nxt_s = ST_SCAN;
      end
    endcase
  end

  // FSM state, column drive and debounce registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r   <= ST_SCAN;
      col_r     <= 2'd0;
      row_r     <= 2'd0;
      deb_r     <= '0;
      col_drv_r <= 4'b1110;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_r     <= '0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      col_r     <= col_nxt_s;
      row_r     <= row_nxt_s;
      deb_r     <= deb_nxt_s;
      col_drv_r <= col_drive(col_nxt_s);
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_r     <= rep_nxt_s;
`endif
    end
  end

  // Key latch and interrupt pulse; a report restarts the pulse even mid-pulse.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      key_r   <= 4'h0;
      pulse_r <= '0;
      intr_r  <= 1'b1;
    end else if (report_s) begin
      key_r   <= {row_r, col_r};
      pulse_r <= PULSE_LOAD;
      intr_r  <= 1'b0;
    end else if (pulse_r != '0) begin
      pulse_r <= pulse_r - PW'(1);
    end else begin
      intr_r  <= 1'b1;
    end
  end

  assign KeyCol  = col_drv_r;
  assign Key     = key_r;
  assign KeyIntr = intr_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with a behavioural 4x4 key
// matrix; pulse expectations follow KEYPAD_AUTOREPEAT_EN when it is defined.
module tb_keypad_scanner;

  logic       Clk;
  logic       Rst_n;
  logic [3:0] KeyRow;
  logic [3:0] KeyCol;
  logic [3:0] Key;
  logic       KeyIntr;

  logic [15:0] pressed;
  int          errors;
  int          checks;

  int          pulse_cnt;
  int          low_run;
  int          last_width;
  logic        prev_intr;

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3),
    .INTR_WIDTH   (8),
    .REPEAT_TICKS (20)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .KeyRow  (KeyRow),
    .KeyCol  (KeyCol),
    .Key     (Key),
    .KeyIntr (KeyIntr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Key matrix: a pressed key shorts its row to the column currently driven low.
  always_comb begin
    KeyRow = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !KeyCol[c]) KeyRow[r] = 1'b0;
      end
    end
  end

  // Interrupt monitor: counts falling edges and measures low-pulse width.
  initial begin
    pulse_cnt  = 0;
    low_run    = 0;
    last_width = 0;
    prev_intr  = 1'b1;
  end
  always @(negedge Clk) begin
    prev_intr <= KeyIntr;
    if (prev_intr === 1'b1 && KeyIntr === 1'b0) pulse_cnt <= pulse_cnt + 1;
    if (KeyIntr === 1'b0) begin
      low_run <= low_run + 1;
    end else begin
      if (prev_intr === 1'b0) last_width <= low_run;
      low_run <= 0;
    end
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  task automatic wait_intr_low(input int budget, output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (n < budget && !seen) begin
      @(negedge Clk);
      n++;
      if (KeyIntr === 1'b0) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_col [5];
    int         at_edge [5];
    int         k;
    exp_col[0] = 4'b1110; at_edge[0] = 3;
    exp_col[1] = 4'b1101; at_edge[1] = 4;
    exp_col[2] = 4'b1011; at_edge[2] = 8;
    exp_col[3] = 4'b0111; at_edge[3] = 12;
    exp_col[4] = 4'b1110; at_edge[4] = 16;
    Rst_n   = 1'b0;
    pressed = 16'h0000;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++; if (KeyCol !== 4'b1110) begin errors++; $display("FAIL reset_keycol: got %b expected %b", KeyCol, 4'b1110); end
    checks++; if (Key !== 4'h0) begin errors++; $display("FAIL reset_key: got %h expected %h", Key, 4'h0); end
    checks++; if (KeyIntr !== 1'b1) begin errors++; $display("FAIL reset_intr: got %b expected %b", KeyIntr, 1'b1); end
    Rst_n = 1'b1;
    k = 0;
    for (int e = 1; e <= 16; e++) begin
      @(negedge Clk);
      if (k < 5 && e == at_edge[k]) begin
        checks++;
        if (KeyCol !== exp_col[k]) begin
          errors++;
          $display("FAIL scan_col_edge%0d: got %b expected %b", e, KeyCol, exp_col[k]);
        end
        k++;
      end
    end
  endtask

  task automatic test_single_press;
    int   n;
    bit   seen;
    int   p0;
    logic [3:0] seen_cols;
    p0 = pulse_cnt;
    pressed = 16'h0200;
    wait_intr_low(60, n, seen);
    checks++; if (!seen || n > 31) begin errors++; $display("FAIL press_latency: got %0d cycles (seen=%0d) expected <= 31", n, seen); end
    checks++; if (Key !== 4'h9) begin errors++; $display("FAIL press_key: got %h expected %h", Key, 4'h9); end
    wait_cycles(12);
    checks++; if (last_width !== 8) begin errors++; $display("FAIL press_width: got %0d expected %0d", last_width, 8); end
    checks++; if (KeyCol !== 4'b1101) begin errors++; $display("FAIL hold_col: got %b expected %b", KeyCol, 4'b1101); end
    wait_cycles(200 - n - 12);
    pressed = 16'h0000;
    wait_cycles(40);
    checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL press_pulses: got %0d expected %0d", pulse_cnt - p0, 1); end
    checks++; if (Key !== 4'h9) begin errors++; $display("FAIL key_after_release: got %h expected %h", Key, 4'h9); end
    seen_cols = 4'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      seen_cols = seen_cols | ~KeyCol;
    end
    checks++; if (seen_cols !== 4'hF) begin errors++; $display("FAIL rescan_after_release: got %b expected %b", seen_cols, 4'hF); end
  endtask

  task automatic test_bounce;
    int   n;
    int   p0;
    logic [3:0] seen_cols;
    n = 0;
    while (KeyCol !== 4'b0111 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    checks++; if (KeyCol !== 4'b0111) begin errors++; $display("FAIL bounce_find_col3: got %b expected %b", KeyCol, 4'b0111); end
    p0 = pulse_cnt;
    pressed = 16'h0008;
    wait_cycles(8);
    pressed = 16'h0000;
    wait_cycles(40);
    checks++; if (pulse_cnt - p0 !== 0 || Key !== 4'h9) begin errors++; $display("FAIL bounce_no_report: got pulses=%0d key=%h expected pulses=0 key=9", pulse_cnt - p0, Key); end
    seen_cols = 4'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      seen_cols = seen_cols | ~KeyCol;
    end
    checks++; if (seen_cols !== 4'hF) begin errors++; $display("FAIL bounce_scan_continues: got %b expected %b", seen_cols, 4'hF); end
  endtask

  task automatic test_multi_row;
    int n;
    bit seen;
    int p0;
    p0 = pulse_cnt;
    pressed = 16'h4040;
    wait_intr_low(60, n, seen);
    checks++; if (!seen || Key !== 4'h6) begin errors++; $display("FAIL multi_row_key: got %h (seen=%0d) expected %h", Key, seen, 4'h6); end
    wait_cycles(100);
    pressed = 16'h0000;
    wait_cycles(40);
    checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL multi_row_pulses: got %0d expected %0d", pulse_cnt - p0, 1); end
    checks++; if (last_width !== 8) begin errors++; $display("FAIL multi_row_width: got %0d expected %0d", last_width, 8); end
  endtask

  task automatic test_long_hold;
    int p0;
    int exp_pulses;
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_pulses = 5;
`else
    exp_pulses = 1;
`endif
    p0 = pulse_cnt;
    pressed = 16'h0001;
    wait_cycles(400);
    pressed = 16'h0000;
    wait_cycles(40);
    checks++; if (pulse_cnt - p0 !== exp_pulses) begin errors++; $display("FAIL long_hold_pulses: got %0d expected %0d", pulse_cnt - p0, exp_pulses); end
    checks++; if (Key !== 4'h0) begin errors++; $display("FAIL long_hold_key: got %h expected %h", Key, 4'h0); end
  endtask

  task automatic test_reset_mid_pulse;
    int n;
    bit seen;
    int p0;
    pressed = 16'h0020;
    wait_intr_low(60, n, seen);
    checks++; if (!seen || Key !== 4'h5) begin errors++; $display("FAIL midrst_pre_key: got %h (seen=%0d) expected %h", Key, seen, 4'h5); end
    wait_cycles(3);
    Rst_n   = 1'b0;
    pressed = 16'h0000;
    @(negedge Clk);
    checks++; if (KeyIntr !== 1'b1) begin errors++; $display("FAIL midrst_intr: got %b expected %b", KeyIntr, 1'b1); end
    checks++; if (Key !== 4'h0) begin errors++; $display("FAIL midrst_key: got %h expected %h", Key, 4'h0); end
    checks++; if (KeyCol !== 4'b1110) begin errors++; $display("FAIL midrst_col: got %b expected %b", KeyCol, 4'b1110); end
    wait_cycles(2);
    Rst_n = 1'b1;
    p0 = pulse_cnt;
    wait_cycles(100);
    checks++; if (pulse_cnt - p0 !== 0 || KeyIntr !== 1'b1) begin errors++; $display("FAIL midrst_no_pulse: got pulses=%0d intr=%b expected pulses=0 intr=1", pulse_cnt - p0, KeyIntr); end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    Rst_n   = 1'b0;
    pressed = 16'h0000;
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_row();
    test_long_hold();
    test_reset_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
